spi_slave: RTL and testbench
============================

// Module: spi_slave
//
// PURPOSE
//   Bit-bang SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first. It is the far-end
//   peer of spi_master: it consumes spi_cs_n/spi_clock/spi_mosi and drives
//   spi_miso. Received words go downstream with a put strobe. Reply words are
//   pulled from an upstream source (ROM/FIFO) with a get/empty handshake,
//   the same contract spi_master uses. SPI inputs are oversampled by the
//   system clock; no logic runs on spi_clock.
//
// PARAMETERS
//   W      8   word width in bits (W >= 2)
//
// PORTS
//   clock      in   1  system clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   in         in   W  reply word from upstream, valid when empty=0
//   get        out  1  1-cycle strobe: consumed `in` this cycle
//   empty      in   1  upstream has no reply word
//   out        out  W  last fully received word
//   put        out  1  1-cycle strobe: `out` holds a new word
//   spi_cs_n   in   1  chip select, active low (asynchronous to clock)
//   spi_clock  in   1  SPI clock (asynchronous to clock)
//   spi_mosi   in   1  master-out data
//   spi_miso   out  1  slave-out data
//
// BEHAVIOUR
// - Reset (reset_n=0, async): get=0, put=0, out=0, spi_miso=0, bit count=0,
//   rx/tx shift registers=0, all sync flops=1 for cs_n and 0 for clock/mosi.
// - Sync: cs_n, spi_clock and mosi each pass through 2 flops, plus a 3rd flop
//   for edge detect. Events below act on the synchronised (delayed) signals.
//   Requirement on the master: SCK high/low phase >= 3 clock periods. MOSI
//   must be stable >= 1 clock before SCK rises.
// - States: IDLE (cs_n=1) and SHIFT (cs_n=0).
// - IDLE -> SHIFT on a synced cs_n falling edge. In that cycle:
//     empty=0 -> tx<=in and get=1 for 1 cycle; empty=1 -> tx<=0, get=0.
//     Bit count<=0.
// - In SHIFT, spi_miso = tx[W-1]. The master samples it on the first SCK
//   rise.
// - On a synced SCK rise: rx<={rx[W-2:0],mosi}, count++. When count reaches
//   W: out<={rx[W-2:0],mosi}, put=1 next cycle (for 1 cycle only), count<=0,
//   and set a reload flag.
// - On a synced SCK fall: if the reload flag is set, reload tx from `in`
//   with the same empty/get rule and clear the flag. Otherwise tx<=tx<<1.
//   Back-to-back words therefore need no cs_n toggle.
// - Latency: put/out update 3 clock edges after raw spi_clock rises on the
//   W-th bit.
// - SHIFT -> IDLE on a synced cs_n rising edge, at any bit count. A partial
//   word is discarded (no put). Count is cleared, the reload flag is
//   cleared, and spi_miso=0. SCK edges seen while cs_n=1 are ignored.
// - At most one get per word. get is never asserted while empty=1.
// - Async reset mid-word: immediate return to reset values. A transfer
//   resumes only after the next cs_n falling edge.
//
// TESTING
// 1. Source holds 0xA5 (empty=0). Master sends 0x3C, SCK half-period 4
//    clocks. Expect one get at cs_n fall, spi_miso bits 1,0,1,0,0,1,0,1,
//    put once with out=0x3C.
// 2. empty=1, master sends 0xFF. Expect get never asserted, MISO=0 for all
//    8 bits, out=0xFF with put.
// 3. Two words 0x12, 0x34 in one cs_n window; source gives 0x81 then 0x7E.
//    Expect 2 puts (0x12, 0x34), 2 gets, MISO stream 0x81 then 0x7E.
// 4. cs_n deasserted after 5 bits of 0xC3, then a full 0x5A. Expect no put
//    for the aborted word, then put with out=0x5A (count restarted).
// 5. reset_n pulsed low mid-word. Expect put=get=0 and spi_miso=0 at once.
//    The next cs_n window transfers 0x99 correctly.
// 6. Loop spi_miso to a model master, run 16 random words. Every received
//    word equals the word sent in the same slot, with no stuck strobes.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave.
// The SPI pins are oversampled by the system clock, so no logic runs on spi_clock.
// Received words are passed downstream with a put strobe.
// Reply words are pulled from an upstream source with a get/empty handshake.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in         reply word from upstream, valid when empty=0
//   get        1-cycle strobe: `in` is consumed this cycle
//   empty      upstream has no reply word
//   out        last fully received word
//   put        1-cycle strobe: `out` holds a new word
//   spi_cs_n   chip select, active low (asynchronous)
//   spi_clock  SPI clock (asynchronous)
//   spi_mosi   master-out data (asynchronous)
//   spi_miso   slave-out data
module spi_slave #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] in,
  output logic         get,
  input  logic         empty,
  output logic [W-1:0] out,
  output logic         put,
  input  logic         spi_cs_n,
  input  logic         spi_clock,
  input  logic         spi_mosi,
  output logic         spi_miso
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [2:0]    cs_q;
  logic [2:0]    sck_q;
  logic [1:0]    mosi_q;
  logic [W-2:0]  rx;
  logic [W-1:0]  rx_next;
  logic [W-1:0]  tx;
  logic [CW-1:0] cnt;
  logic          reload;

  logic cs_fall, cs_rise, sck_rise, sck_fall, mosi_s, load_req;

  // Synchroniser stage.
  // Bit 1 is the synchronised level and bit 2 is the previous level,
  // which is used for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sck_q  <= {sck_q[1:0], spi_clock};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign mosi_s   = mosi_q[1];
  assign rx_next  = {rx, mosi_s};

  // A reply word is loaded at the start of a window and after each complete word.
  // A cs_n rise overrides a coincident SCK fall.
  // This prevents a master that ends the window with SCK low and cs_n high together
  // from pulling a spare word.
  always_comb begin
    load_req = 1'b0;
    if (state == IDLE)
      load_req = cs_fall;
    else
      load_req = ~cs_rise & sck_fall & reload;
    get = load_req & ~empty;
  end

  assign spi_miso = (state == SHIFT) & tx[W-1];

  // Protocol stage: FSM, shift registers and output word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rx     <= '0;
      tx     <= '0;
      cnt    <= '0;
      reload <= 1'b0;
      out    <= '0;
      put    <= 1'b0;
    end else begin
      put <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state  <= SHIFT;
            tx     <= empty ? '0 : in;
            cnt    <= '0;
            reload <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // A partial word is simply dropped.
            state  <= IDLE;
            cnt    <= '0;
            reload <= 1'b0;
          end else if (sck_rise) begin
            rx <= rx_next[W-2:0];
            if (cnt == CW'(W - 1)) begin
              out    <= rx_next;
              put    <= 1'b1;
              cnt    <= '0;
              reload <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (reload) begin
              tx     <= empty ? '0 : in;
              reload <= 1'b0;
            end else begin
              tx <= {tx[W-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] in = '0;
  logic         get;
  logic         empty = 1'b1;
  logic [W-1:0] out;
  logic         put;
  logic         spi_cs_n;
  logic         spi_clock;
  logic         spi_mosi;
  logic         spi_miso;

  spi_slave #(.W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (in),
    .get       (get),
    .empty     (empty),
    .out       (out),
    .put       (put),
    .spi_cs_n  (spi_cs_n),
    .spi_clock (spi_clock),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Upstream reply source: a queue of words plus a read index.
  logic [7:0] src_words[$];
  int         src_idx = 0;
  int         get_cnt = 0;
  int         bad_get = 0;

  always @(negedge clock) begin
    if (src_idx < src_words.size()) begin
      empty = 1'b0;
      in    = src_words[src_idx];
    end else begin
      empty = 1'b1;
      in    = '0;
    end
  end

  always @(posedge clock) begin
    if (get) begin
      if (empty) bad_get++;
      get_cnt++;
      src_idx <= src_idx + 1;
    end
  end

  // Downstream sink: collect every put word and flag strobes that stick.
  logic [7:0] rx_q[$];
  logic       put_prev = 1'b0;
  int         put_stuck = 0;

  always @(negedge clock) begin
    if (put) rx_q.push_back(out);
    if (put && put_prev) put_stuck++;
    put_prev = put;
  end

  // Model master.
  logic [7:0] mwords[$];
  logic [7:0] miso_words[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The last word is cut after last_bits bits.
  // Its final SCK fall coincides with cs_n rising.
  task automatic spi_window(input int last_bits);
    int         nw;
    int         nb;
    logic [7:0] mw;
    nw = mwords.size();
    spi_cs_n = 1'b0;
    spi_mosi = mwords[0][7];
    tick(HALF);
    for (int i = 0; i < nw; i++) begin
      mw = '0;
      nb = (i == nw - 1) ? last_bits : 8;
      for (int b = 0; b < nb; b++) begin
        mw = {mw[6:0], spi_miso};
        spi_clock = 1'b1;
        tick(HALF);
        spi_clock = 1'b0;
        if (i == nw - 1 && b == nb - 1) spi_cs_n = 1'b1;
        else if (b == 7) spi_mosi = mwords[i+1][7];
        else spi_mosi = mwords[i][6-b];
        tick(HALF);
      end
      if (nb == 8) miso_words.push_back(mw);
    end
    spi_mosi = 1'b0;
    tick(2 * HALF);
  endtask

  // Expected results come from the transaction view.
  // Every complete word is put unchanged.
  // Reply slot i carries the i-th available source word, or zero once the source is dry.
  task automatic run_case(input string tag, input int last_bits);
    int rb, g0, s0, avail, nw, nfull, expg;
    logic [7:0] exp_m;
    rb    = rx_q.size();
    g0    = get_cnt;
    s0    = src_idx;
    avail = src_words.size() - s0;
    nw    = mwords.size();
    nfull = (last_bits == 8) ? nw : nw - 1;
    expg  = (nw < avail) ? nw : avail;
    miso_words.delete();
    spi_window(last_bits);
    check({tag, "_puts"}, rx_q.size() - rb, nfull);
    check({tag, "_gets"}, get_cnt - g0, expg);
    for (int i = 0; i < nfull; i++) begin
      if (rb + i < rx_q.size())
        check($sformatf("%s_rx%0d", tag, i), int'(rx_q[rb+i]), int'(mwords[i]));
      exp_m = (i < avail) ? src_words[s0+i] : 8'h00;
      if (i < miso_words.size())
        check($sformatf("%s_miso%0d", tag, i), int'(miso_words[i]), int'(exp_m));
    end
  endtask

  initial begin
    int sent, nw, k;
    reset_n   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_clock = 1'b0;
    spi_mosi  = 1'b0;
    tick(3);
    check("rst_get",  int'(get), 0);
    check("rst_put",  int'(put), 0);
    check("rst_out",  int'(out), 0);
    check("rst_miso", int'(spi_miso), 0);
    reset_n = 1'b1;
    tick(3);

    // Reply 0xA5 against received 0x3C.
    src_words.push_back(8'hA5);
    mwords = '{8'h3C};
    run_case("t1", 8);

    // Empty source.
    mwords = '{8'hFF};
    run_case("t2", 8);
    check("t2_miso_idle", int'(spi_miso), 0);

    // Two words in one window.
    src_words.push_back(8'h81);
    src_words.push_back(8'h7E);
    mwords = '{8'h12, 8'h34};
    run_case("t3", 8);

    // Aborted word followed by a full one.
    src_words.push_back(8'h11);
    mwords = '{8'hC3};
    run_case("t4a", 5);
    src_words.push_back(8'h22);
    mwords = '{8'h5A};
    run_case("t4b", 8);

    // Reset in the middle of a word.
    src_words.push_back(8'h66);
    spi_cs_n = 1'b0;
    spi_mosi = 1'b1;
    tick(HALF);
    repeat (3) begin
      spi_clock = 1'b1;
      tick(HALF);
      spi_clock = 1'b0;
      tick(HALF);
    end
    check("t5_pre_miso", int'(spi_miso), 0);
    reset_n = 1'b0;
    #1;
    check("t5_put",  int'(put), 0);
    check("t5_get",  int'(get), 0);
    check("t5_miso", int'(spi_miso), 0);
    check("t5_out",  int'(out), 0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    src_words.push_back(8'h44);
    mwords = '{8'h99};
    run_case("t5", 8);

    // Random words in random-length windows, with a source that sometimes runs dry.
    sent = 0;
    while (sent < 16) begin
      nw = $urandom_range(1, 4);
      if (sent + nw > 16) nw = 16 - sent;
      mwords.delete();
      for (int i = 0; i < nw; i++) mwords.push_back(8'($urandom));
      k = $urandom_range(0, nw);
      for (int i = 0; i < k; i++) src_words.push_back(8'($urandom));
      run_case($sformatf("t6_%0d", sent), 8);
      sent += nw;
    end

    check("no_get_when_empty", bad_get, 0);
    check("no_stuck_put", put_stuck, 0);
    check("idle_get", int'(get), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
